// File: rtl/mitchell_log_divider.sv
// Three-stage signed divider built on Mitchell's log approximation:
// leading-one log, log subtraction, then piecewise-linear antilog with sign and saturation.
module mitchell_log_divider #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] q,
    output logic                    div_by_zero,
    output logic                    sat
);
    localparam int FW = WIDTH - 1;
    localparam int KW = $clog2(WIDTH);
    localparam int DW = KW + FW + 2;
    localparam int QW = DW - FW;
    localparam logic [WIDTH:0]         MAG_MAX = (WIDTH+1)'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH-1:0] Q_MAX  = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH-1:0] Q_MIN  = {1'b1, {(WIDTH - 1){1'b0}}};

    function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] m);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Normalising the leading one up to bit FW leaves the exact fraction below it.
    function automatic logic [FW-1:0] log_frac(input logic [WIDTH-1:0] m, input logic [KW-1:0] k);
        return FW'(m << (FW - int'(k)));
    endfunction

    // ((1.F) << Kq) >> FW folded into one right shift, since Kq never exceeds FW.
    function automatic logic [WIDTH:0] antilog(input logic signed [QW-1:0] kq, input logic [FW-1:0] fq);
        logic [WIDTH:0] one_f;
        one_f = {2'b01, fq};
        if (kq[QW-1]) return '0;
        return one_f >> (FW - int'(kq));
    endfunction

    // Returns {sat, q}; only the positive side can overflow.
    function automatic logic [WIDTH:0] sign_sat(input logic [WIDTH:0] mag, input logic neg);
        if (neg) return {1'b0, WIDTH'(-mag)};
        if (mag > MAG_MAX) return {1'b1, Q_MAX};
        return {1'b0, mag[WIDTH-1:0]};
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2;

    logic [WIDTH-1:0] ma_c, mb_c;
    logic [KW-1:0]    ka_c, kb_c;

    logic [KW-1:0] ka_p0, kb_p0;
    logic [FW-1:0] fa_p0, fb_p0;
    logic          neg_p0, za_p0, zb_p0, an_p0;

    logic signed [DW-1:0] d_c;
    logic signed [QW-1:0] kq_c;
    logic [FW-1:0]        fq_c;

    logic signed [QW-1:0] kq_p1;
    logic [FW-1:0]        fq_p1;
    logic                 neg_p1, za_p1, zb_p1, an_p1;

    logic [WIDTH:0]          mag_c;
    logic signed [WIDTH-1:0] q_c;
    logic                    sat_c, dz_c;

    assign en        = !vld_p2 || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2;

    // Stage 1: magnitudes and leading-one position
    always_comb begin
        ma_c = a[WIDTH-1] ? unsigned'(-a) : unsigned'(a);
        mb_c = b[WIDTH-1] ? unsigned'(-b) : unsigned'(b);
        ka_c = lead_one(ma_c);
        kb_c = lead_one(mb_c);
    end

    // Stage 2: log-domain subtraction, floor split into characteristic and fraction
    always_comb begin
        d_c  = $signed({2'b00, ka_p0, fa_p0}) - $signed({2'b00, kb_p0, fb_p0});
        kq_c = d_c[DW-1:FW];
        fq_c = d_c[FW-1:0];
    end

    // Stage 3: antilog, sign, saturation and zero-operand overrides
    always_comb begin
        mag_c          = antilog(kq_p1, fq_p1);
        {sat_c, q_c}   = sign_sat(mag_c, neg_p1);
        dz_c           = 1'b0;
        if (za_p1) begin
            q_c   = '0;
            sat_c = 1'b0;
            dz_c  = zb_p1;
        end else if (zb_p1) begin
            q_c   = an_p1 ? Q_MIN : Q_MAX;
            sat_c = 1'b0;
            dz_c  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            q           <= '0;
            div_by_zero <= 1'b0;
            sat         <= 1'b0;
        end else if (en) begin
            vld_p0      <= in_valid;
            vld_p1      <= vld_p0;
            vld_p2      <= vld_p1;
            q           <= q_c;
            div_by_zero <= dz_c;
            sat         <= sat_c;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            ka_p0  <= ka_c;
            kb_p0  <= kb_c;
            fa_p0  <= log_frac(ma_c, ka_c);
            fb_p0  <= log_frac(mb_c, kb_c);
            neg_p0 <= a[WIDTH-1] ^ b[WIDTH-1];
            za_p0  <= (a == '0);
            zb_p0  <= (b == '0);
            an_p0  <= a[WIDTH-1];

            kq_p1  <= kq_c;
            fq_p1  <= fq_c;
            neg_p1 <= neg_p0;
            za_p1  <= za_p0;
            zb_p1  <= zb_p0;
            an_p1  <= an_p0;
        end
    end

endmodule

// File: tb/tb_mitchell_log_divider.sv
// Bench for mitchell_log_divider: arithmetic reference model with scoreboard,
// directed literal cases, random streaming under random backpressure, and async reset.
module tb_mitchell_log_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [7:0] a = '0;
    logic signed [7:0] b = '0;
    logic in_ready, out_valid, div_by_zero, sat;
    logic signed [7:0] q;
    logic rand_rdy = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic signed [7:0] q;
        logic              dz;
        logic              sat;
    } res_t;

    res_t exp_q[$];
    logic prev_stall = 1'b0;
    logic signed [7:0] prev_q = '0;
    logic prev_dz = 1'b0;
    logic prev_sat = 1'b0;

    mitchell_log_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .div_by_zero(div_by_zero), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int flog2(input int m);
        int k = 0;
        while ((2 << k) <= m) k++;
        return k;
    endfunction

    // Reference: logs as real-valued k + F/128, floor split, truncating antilog.
    function automatic res_t model(input int av, input int bv);
        res_t r;
        int ma, mb, ka, kb, fa, fb, d, kq, fq, mag;
        r = '0;
        if (av == 0) begin
            r.dz = (bv == 0);
            return r;
        end
        if (bv == 0) begin
            r.dz = 1'b1;
            r.q  = (av > 0) ? 8'sd127 : -8'sd128;
            return r;
        end
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        ka = flog2(ma);
        kb = flog2(mb);
        fa = ma * (2 ** (7 - ka)) - 128;
        fb = mb * (2 ** (7 - kb)) - 128;
        d  = (ka * 128 + fa) - (kb * 128 + fb);
        kq = (d >= 0) ? d / 128 : -((-d + 127) / 128);
        fq = d - kq * 128;
        mag = (kq < 0) ? 0 : ((128 + fq) * (2 ** kq)) / 128;
        if ((av < 0) != (bv < 0)) r.q = 8'(-mag);
        else if (mag > 127) begin
            r.q   = 8'sd127;
            r.sat = 1'b1;
        end else r.q = 8'(mag);
        return r;
    endfunction

    // Scoreboard: inputs/handshakes are stable at the falling edge.
    always @(negedge clk or negedge rst_n) begin
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, (!out_valid || out_ready));
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_q", q, prev_q);
                chk("stall_dz", div_by_zero, prev_dz);
                chk("stall_sat", sat, prev_sat);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: q=%0d appeared, none expected", q);
                end else begin
                    e = exp_q[0];
                    chk("sb_q", q, $signed(e.q));
                    chk("sb_dz", div_by_zero, e.dz);
                    chk("sb_sat", sat, e.sat);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
            prev_stall = out_valid && !out_ready;
            prev_q     = q;
            prev_dz    = div_by_zero;
            prev_sat   = sat;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int av, input int bv);
        int w = 0;
        a = 8'(av);
        b = 8'(bv);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at %0d, want 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input int av, input int bv, input int eq, input int edz, input int esat);
        int n;
        send(av, bv);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 3);
        chk("lit_q", q, eq);
        chk("lit_dz", div_by_zero, edz);
        chk("lit_sat", sat, esat);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        int edges[6] = '{0, 1, -1, 127, -128, 2};
        if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 5)];
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    int da[11] = '{100, -100, 100, 127, -128, -128, 3, 50, -5, 0, 0};
    int db[11] = '{10, 10, 3, 1, 1, -1, 7, 0, 0, 0, -9};
    int dq[11] = '{10, -10, 34, 127, -128, 127, 0, 127, -128, 0, 0};
    int dz[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    int ds[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        res_t r;
        // Pin the reference model with hand-derived values.
        r = model(100, 10);  chk("model_100_10", r.q, 10);
        r = model(100, 3);   chk("model_100_3", r.q, 34);
        r = model(-128, -1); chk("model_sat_q", r.q, 127); chk("model_sat_flag", r.sat, 1);
        r = model(3, 7);     chk("model_3_7", r.q, 0);
        r = model(8, 3);     chk("model_8_3", r.q, 3);
        r = model(64, 3);    chk("model_64_3", r.q, 24);
        r = model(-5, 0);    chk("model_dz_q", r.q, -128); chk("model_dz_flag", r.dz, 1);

        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_q", q, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_q", q, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) send_chk(da[i], db[i], dq[i], dz[i], ds[i]);

        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(pick(), pick());
        in_valid = 1'b0;
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();

        send(20, 4);
        send(-60, 7);
        send(90, -3);
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_q", q, 0);
        chk("async_rst_dz", div_by_zero, 0);
        chk("async_rst_sat", sat, 0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_valid", out_valid, 0);
        send_chk(100, 3, 34, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
